shift_ctrl: RTL and testbench

//  Sequencer for the shift datapath: shift-amount mux (5-bit, 3-bit selector) feeding the shift register unit.

---
 rtl/shift_ctrl_if.sv | 22 ++
 rtl/shift_ctrl.sv | 76 +++++++
 tb/tb_shift_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/shift_ctrl_if.sv
// shift_ctrl_if: request/response bundle between the main control FSM and the shift sequencer
interface shift_ctrl_if;
    logic       start;
    logic [2:0] shift_kind;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] shamt_sel;
    logic       shift_src_sel;
    logic [2:0] shift_op;
    logic       mem_rd;
    logic       reg_wr;
    logic       reg_dst_sel;
    modport master (
        output start, shift_kind,
        input  busy, done, err, shamt_sel, shift_src_sel, shift_op, mem_rd, reg_wr, reg_dst_sel
    );
    modport slave (
        input  start, shift_kind,
        output busy, done, err, shamt_sel, shift_src_sel, shift_op, mem_rd, reg_wr, reg_dst_sel
    );
endinterface

// File: rtl/shift_ctrl.sv
// shift_ctrl: sequences one decoded shift instruction through amount select, optional memory read, load, shift and writeback
module shift_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input logic        clk,
    input logic        reset,
    shift_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, MEMRD, LOAD, SHIFT, WB, ERR} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       kind_q, kind_d, sel_q, sel_d;
    logic             src_q, src_d, dst_q, dst_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            kind_q  <= '0;
            sel_q   <= '0;
            src_q   <= 1'b0;
            dst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            sel_q   <= sel_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        sel_d   = sel_q;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            IDLE: if (bus.start) begin
                kind_d  = bus.shift_kind;
                cnt_d   = '0;
                state_d = bus.shift_kind == 3'b111 ? ERR : bus.shift_kind == 3'b110 ? MEMRD : LOAD;
                sel_d   = bus.shift_kind == 3'b110 ? 3'b011 :
                          bus.shift_kind == 3'b101 ? 3'b001 :
                          (bus.shift_kind == 3'b011 || bus.shift_kind == 3'b100) ? 3'b010 : 3'b000;
                src_d   = bus.shift_kind == 3'b101;
                dst_d   = bus.shift_kind == 3'b101;
            end
            MEMRD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MEM_LAT - 1)) state_d = LOAD;
            end
            LOAD:  state_d = SHIFT;
            SHIFT: state_d = WB;
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                src_d   = 1'b0;
                dst_d   = 1'b0;
            end
        endcase
    end
    assign bus.busy          = state_q != IDLE;
    assign bus.done          = state_q == WB;
    assign bus.reg_wr        = state_q == WB;
    assign bus.err           = state_q == ERR;
    assign bus.mem_rd        = state_q == MEMRD;
    assign bus.shamt_sel     = sel_q;
    assign bus.shift_src_sel = src_q;
    assign bus.reg_dst_sel   = dst_q;
    assign bus.shift_op      = state_q == LOAD ? 3'b001 :
                               state_q != SHIFT ? 3'b000 :
                               kind_q == 3'b001 ? 3'b011 :
                               (kind_q == 3'b000 || kind_q == 3'b011 || kind_q == 3'b101) ? 3'b010 : 3'b100;
endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: randomized scoreboard bench for shift_ctrl against a per-instruction timeline model
module tb_shift_ctrl;
    localparam int MEM_LAT = 2;
    typedef struct {
        int         acc;
        int         lat;
        logic       err;
        logic       sram;
        logic [2:0] sel;
        logic       src;
        logic       dst;
        logic [2:0] code;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   passes = 0;
    int   free_k = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];
    shift_ctrl_if bus ();
    shift_ctrl #(.MEM_LAT(MEM_LAT), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passes++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", n, a, e, cyc);
    endtask
    function automatic exp_t model(input logic [2:0] k, input int acc);
        exp_t m;
        m.acc  = acc;
        m.err  = k == 3'd7;
        m.sram = k == 3'd6;
        m.lat  = m.err ? 1 : m.sram ? MEM_LAT + 3 : 3;
        m.sel  = k == 3'd6 ? 3'd3 : k == 3'd5 ? 3'd1 : (k == 3'd3 || k == 3'd4) ? 3'd2 : 3'd0;
        m.src  = k == 3'd5;
        m.dst  = k == 3'd5;
        m.code = k == 3'd1 ? 3'd3 : (k == 3'd0 || k == 3'd3 || k == 3'd5) ? 3'd2 : 3'd4;
        return m;
    endfunction
    task automatic step(input logic s, input logic [2:0] k, input logic r);
        exp_t m;
        @(negedge clk);
        #1;
        bus.start      = s;
        bus.shift_kind = k;
        reset          = r;
        if (r) begin
            q.delete();
            free_k = cyc + 1;
        end else if (s && cyc >= free_k) begin
            m = model(k, cyc);
            q.push_back(m);
            free_k = cyc + m.lat + 1;
        end
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_t h;
                int d, ld;
                logic e_busy, e_mem, e_done, e_err, e_src, e_dst;
                logic [2:0] e_op, e_sel;
                d = 0;
                e_busy = 0; e_mem = 0; e_done = 0; e_err = 0; e_src = 0; e_dst = 0; e_op = 0; e_sel = 0;
                if (q.size() > 0) begin
                    h      = q[0];
                    d      = cyc - h.acc;
                    ld     = h.sram ? MEM_LAT + 1 : 1;
                    e_busy = 1'b1;
                    e_mem  = h.sram && d <= MEM_LAT;
                    e_op   = h.err ? 3'd0 : d == ld ? 3'd1 : d == ld + 1 ? h.code : 3'd0;
                    e_done = !h.err && d == h.lat;
                    e_err  = h.err && d == 1;
                    e_sel  = h.sel;
                    e_src  = h.src;
                    e_dst  = h.dst;
                end
                chk("busy", 32'(bus.busy), 32'(e_busy));
                chk("done", 32'(bus.done), 32'(e_done));
                chk("reg_wr", 32'(bus.reg_wr), 32'(e_done));
                chk("err", 32'(bus.err), 32'(e_err));
                chk("mem_rd", 32'(bus.mem_rd), 32'(e_mem));
                chk("shift_op", 32'(bus.shift_op), 32'(e_op));
                chk("shamt_sel", 32'(bus.shamt_sel), 32'(e_sel));
                chk("shift_src_sel", 32'(bus.shift_src_sel), 32'(e_src));
                chk("reg_dst_sel", 32'(bus.reg_dst_sel), 32'(e_dst));
                if (bus.done || bus.err) begin
                    if (q.size() == 0) chk("spurious_completion", 32'(1), 32'(0));
                    else begin
                        chk("latency", 32'(d), 32'(h.lat));
                        chk("completion_kind", 32'(bus.err), 32'(h.err));
                        void'(q.pop_front());
                    end
                end else if (q.size() > 0 && d > h.lat) begin
                    chk("completion_timeout", 32'(d), 32'(h.lat));
                    void'(q.pop_front());
                end
            end
        end
    end
    initial begin
        bus.start      = 1'b0;
        bus.shift_kind = 3'd0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        step(0, 3'd0, 1);
        step(1, 3'd0, 0);
        repeat (4) step(0, 3'd0, 0);
        step(1, 3'd5, 0);
        repeat (4) step(0, 3'd0, 0);
        step(1, 3'd6, 0);
        repeat (6) step(0, 3'd0, 0);
        step(1, 3'd7, 0);
        repeat (2) step(0, 3'd0, 0);
        step(1, 3'd4, 0);
        step(1, 3'd0, 0);
        step(1, 3'd7, 0);
        step(1, 3'd2, 0);
        step(1, 3'd1, 0);
        repeat (4) step(0, 3'd0, 0);
        step(1, 3'd4, 0);
        step(0, 3'd0, 0);
        step(0, 3'd0, 1);
        step(1, 3'd3, 0);
        repeat (4) step(0, 3'd0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 63) == 0);
        repeat (12) step(0, 3'd0, 0);
        chk("drain", 32'(q.size()), 32'(0));
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
